// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves i_cache fetches and MEM-stage loads/stores
// over an 8-bit RAM port with one-cycle read latency. Data accesses win over fetches.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_read_flag,
    input  logic [31:0] inst_read_address,
    output logic        inst_flag,
    output logic [31:0] inst,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_address,
    input  logic [1:0]  data_width,
    input  logic [31:0] data_wdata,
    output logic        data_flag,
    output logic [31:0] data_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    // Requests are levels sampled only in IDLE; completion is signalled by a
    // one-cycle flag pulse, after which the controller spends one cycle in DONE.
    typedef enum logic [2:0] {IDLE, INST_RD, DATA_RD, DATA_WR, DONE} state_t;

    state_t      state, state_n;
    logic [1:0]  k, k_n;
    logic [1:0]  nlast, nlast_n;
    logic        primed, primed_n;
    logic [31:0] wdata, wdata_n;
    logic [31:0] rbuf, rbuf_n;
    logic [31:0] merged;
    logic        inst_flag_n, data_flag_n, mem_wr_n;
    logic [31:0] inst_n, data_rdata_n, mem_a_n;
    logic [7:0]  mem_dout_n;

    // Read buffer with the byte arriving this cycle already in place.
    always_comb begin
        merged = rbuf;
        merged[{k, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_n      = state;
        k_n          = k;
        nlast_n      = nlast;
        primed_n     = primed;
        wdata_n      = wdata;
        rbuf_n       = rbuf;
        inst_n       = inst;
        data_rdata_n = data_rdata;
        inst_flag_n  = 1'b0;
        data_flag_n  = 1'b0;
        mem_a_n      = 32'h0;
        mem_dout_n   = 8'h00;
        mem_wr_n     = 1'b0;
        case (state)
            IDLE: begin
                k_n      = 2'd0;
                primed_n = 1'b0;
                rbuf_n   = 32'h0;
                if (data_req) begin
                    mem_a_n = data_address;
                    case (data_width)
                        2'b00:   nlast_n = 2'd0;
                        2'b01:   nlast_n = 2'd1;
                        default: nlast_n = 2'd3;
                    endcase
                    if (data_we) begin
                        state_n    = DATA_WR;
                        mem_wr_n   = 1'b1;
                        mem_dout_n = data_wdata[7:0];
                        wdata_n    = data_wdata;
                    end else begin
                        state_n = DATA_RD;
                    end
                end else if (inst_read_flag) begin
                    mem_a_n = inst_read_address;
                    nlast_n = 2'd3;
                    state_n = INST_RD;
                end
            end
            INST_RD, DATA_RD: begin
                if (state == INST_RD && !inst_read_flag) begin
                    state_n = IDLE;
                end else begin
                    // First cycle only issues an address; bytes arrive one cycle later.
                    mem_a_n  = mem_a + 32'd1;
                    primed_n = 1'b1;
                    if (primed) begin
                        rbuf_n = merged;
                        if (k == nlast) begin
                            state_n = DONE;
                            mem_a_n = 32'h0;
                            if (state == INST_RD) begin
                                inst_n      = merged;
                                inst_flag_n = 1'b1;
                            end else begin
                                data_rdata_n = merged;
                                data_flag_n  = 1'b1;
                            end
                        end else begin
                            k_n = k + 2'd1;
                        end
                    end
                end
            end
            DATA_WR: begin
                if (k == nlast) begin
                    state_n     = DONE;
                    data_flag_n = 1'b1;
                end else begin
                    k_n        = k + 2'd1;
                    mem_a_n    = mem_a + 32'd1;
                    mem_wr_n   = 1'b1;
                    mem_dout_n = wdata[15:8];
                    wdata_n    = {8'h00, wdata[31:8]};
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= 2'd0;
            nlast      <= 2'd0;
            primed     <= 1'b0;
            wdata      <= 32'h0;
            rbuf       <= 32'h0;
            inst       <= 32'h0;
            inst_flag  <= 1'b0;
            data_rdata <= 32'h0;
            data_flag  <= 1'b0;
            mem_a      <= 32'h0;
            mem_dout   <= 8'h00;
            mem_wr     <= 1'b0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            nlast      <= nlast_n;
            primed     <= primed_n;
            wdata      <= wdata_n;
            rbuf       <= rbuf_n;
            inst       <= inst_n;
            inst_flag  <= inst_flag_n;
            data_rdata <= data_rdata_n;
            data_flag  <= data_flag_n;
            mem_a      <= mem_a_n;
            mem_dout   <= mem_dout_n;
            mem_wr     <= mem_wr_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-wide RAM model, transaction-level shadow memory and
// cycle-exact bus expectations derived from the access rules.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_read_flag;
    logic [31:0] inst_read_address;
    logic        inst_flag;
    logic [31:0] inst;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_address;
    logic [1:0]  data_width;
    logic [31:0] data_wdata;
    logic        data_flag;
    logic [31:0] data_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .inst_read_flag(inst_read_flag), .inst_read_address(inst_read_address),
        .inst_flag(inst_flag), .inst(inst),
        .data_req(data_req), .data_we(data_we), .data_address(data_address),
        .data_width(data_width), .data_wdata(data_wdata),
        .data_flag(data_flag), .data_rdata(data_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    // Physical RAM driven by the DUT, and the shadow memory the model updates.
    bit [7:0] ram    [bit [31:0]];
    bit [7:0] shadow [bit [31:0]];

    always @(posedge clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_inst;
    logic [31:0] exp_rdata;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [7:0] ram_rd(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic bit [7:0] shadow_rd(input bit [31:0] a);
        return shadow.exists(a) ? shadow[a] : 8'h00;
    endfunction

    function automatic int width_bytes(input logic [1:0] w);
        case (w)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    task automatic put_byte(input bit [31:0] a, input bit [7:0] v);
        ram[a]    = v;
        shadow[a] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_mem_a"}, mem_a, 32'h0);
        check_eq({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
        check_eq({tag, "_mem_dout"}, 32'(mem_dout), 32'h0);
        check_eq({tag, "_inst_flag"}, 32'(inst_flag), 32'h0);
        check_eq({tag, "_data_flag"}, 32'(data_flag), 32'h0);
        check_eq({tag, "_inst"}, inst, exp_inst);
        check_eq({tag, "_data_rdata"}, data_rdata, exp_rdata);
    endtask

    // Starts in an IDLE cycle (cycle t) and ends one cycle after DONE, again in IDLE.
    task automatic run_access(input bit is_fetch, input bit is_store, input logic [31:0] addr,
                              input logic [1:0] width, input logic [31:0] wdata,
                              input bit drop_req, input bit hold_fetch, input logic [31:0] fetch_addr);
        int          n;
        int          lat;
        logic [31:0] v;
        n   = is_fetch ? 4 : width_bytes(width);
        lat = is_store ? n + 1 : n + 2;
        if (!is_store) begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(shadow_rd(addr + 32'(k))) << (8 * k));
            exp_q.push_back(v);
        end else begin
            for (int k = 0; k < n; k++) shadow[addr + 32'(k)] = wdata[8 * k +: 8];
        end
        if (is_fetch) begin
            inst_read_flag    = 1'b1;
            inst_read_address = addr;
        end else begin
            data_req     = 1'b1;
            data_we      = is_store;
            data_address = addr;
            data_width   = width;
            data_wdata   = wdata;
            if (hold_fetch) begin
                inst_read_flag    = 1'b1;
                inst_read_address = fetch_addr;
            end
        end
        for (int j = 1; j <= lat; j++) begin
            step();
            if (drop_req && j == 1) begin
                data_req     = 1'b0;
                data_we      = 1'($urandom);
                data_address = $urandom;
                data_width   = 2'($urandom);
                data_wdata   = $urandom;
            end
            if (j <= n) begin
                check_eq("bus_addr", mem_a, addr + 32'(j - 1));
                check_eq("bus_wr", 32'(mem_wr), 32'(is_store));
                check_eq("bus_dout", 32'(mem_dout), is_store ? 32'(wdata[8 * (j - 1) +: 8]) : 32'h0);
            end else begin
                check_eq("bus_wr_tail", 32'(mem_wr), 32'h0);
                if (j == lat) check_eq("done_mem_a", mem_a, 32'h0);
            end
            check_eq("inst_flag", 32'(inst_flag), 32'(is_fetch && j == lat));
            check_eq("data_flag", 32'(data_flag), 32'(!is_fetch && j == lat));
            if (j == lat && !is_store) begin
                v = exp_q.pop_front();
                if (is_fetch) exp_inst = v;
                else          exp_rdata = v;
            end
            check_eq("inst_hold", inst, exp_inst);
            check_eq("rdata_hold", data_rdata, exp_rdata);
        end
        data_req = 1'b0;
        if (!hold_fetch) inst_read_flag = 1'b0;
        step();
        check_idle("after_access");
    endtask

    // Fetch dropped after `cut` cycles in INST_RD; nothing may complete.
    task automatic run_cancel(input logic [31:0] addr, input int cut);
        inst_read_flag    = 1'b1;
        inst_read_address = addr;
        for (int j = 1; j <= cut; j++) begin
            step();
            if (j <= 4) check_eq("cancel_addr", mem_a, addr + 32'(j - 1));
            check_eq("cancel_wr", 32'(mem_wr), 32'h0);
            check_eq("cancel_flag", 32'(inst_flag), 32'h0);
        end
        inst_read_flag    = 1'b0;
        inst_read_address = $urandom;
        for (int j = 0; j < 3; j++) begin
            step();
            check_idle("cancel_idle");
        end
    endtask

    // Word store interrupted by reset after m bytes have been written.
    task automatic run_reset_store(input logic [31:0] addr, input logic [31:0] wdata, input int m);
        data_req     = 1'b1;
        data_we      = 1'b1;
        data_address = addr;
        data_width   = 2'b10;
        data_wdata   = wdata;
        for (int j = 1; j <= m; j++) begin
            step();
            check_eq("rst_store_addr", mem_a, addr + 32'(j - 1));
            check_eq("rst_store_wr", 32'(mem_wr), 32'h1);
            shadow[addr + 32'(j - 1)] = wdata[8 * (j - 1) +: 8];
        end
        rst = 1'b1;
        step();
        exp_inst  = 32'h0;
        exp_rdata = 32'h0;
        check_idle("mid_reset");
        rst      = 1'b0;
        data_req = 1'b0;
        step();
        check_idle("post_mid_reset");
    endtask

    initial begin
        logic [7:0]  exp_b[4];
        logic [31:0] a;
        int          r;
        bit          hf;
        rst               = 1'b1;
        inst_read_flag    = 1'b0;
        inst_read_address = 32'h0;
        data_req          = 1'b0;
        data_we           = 1'b0;
        data_address      = 32'h0;
        data_width        = 2'b00;
        data_wdata        = 32'h0;
        exp_inst          = 32'h0;
        exp_rdata         = 32'h0;
        for (int i = 32'h100; i < 32'h400; i++) put_byte(32'(i), 8'($urandom));
        for (int i = 0; i < 16; i++) begin
            put_byte(32'hFFFF_FFF0 + 32'(i), 8'($urandom));
            put_byte(32'(i), 8'($urandom));
        end
        put_byte(32'h100, 8'h13);
        put_byte(32'h101, 8'h00);
        put_byte(32'h102, 8'h00);
        put_byte(32'h103, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("post_reset");

        run_access(1'b1, 1'b0, 32'h100, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("fetch_0x100", inst, 32'h0000_0013);

        run_access(1'b0, 1'b1, 32'h200, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 4; i++) check_eq("store_word_ram", 32'(ram_rd(32'h200 + 32'(i))), 32'(exp_b[i]));

        run_access(1'b0, 1'b0, 32'h201, 2'b01, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("load_half", data_rdata, 32'h0000_ADBE);
        run_access(1'b0, 1'b0, 32'h201, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("load_byte", data_rdata, 32'h0000_00BE);

        run_access(1'b0, 1'b1, 32'h300, 2'b10, 32'h1234_5678, 1'b0, 1'b1, 32'h300);
        run_access(1'b1, 1'b0, 32'h300, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("fetch_after_store", inst, 32'h1234_5678);

        run_cancel(32'h104, 3);
        run_reset_store(32'hFFFF_FFFE, $urandom, int'($urandom_range(1, 3)));
        run_access(1'b0, 1'b1, 32'hFFFF_FFFF, 2'b01, 32'h0000_A55A, 1'b0, 1'b0, 32'h0);
        check_eq("wrap_hi", 32'(ram_rd(32'hFFFF_FFFF)), 32'h5A);
        check_eq("wrap_lo", 32'(ram_rd(32'h0)), 32'hA5);

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFF8 + $urandom_range(0, 7);
            else                           a = 32'h100 + $urandom_range(0, 32'h2F0);
            r  = int'($urandom_range(0, 9));
            hf = ($urandom_range(0, 3) == 0);
            if (r <= 2) begin
                run_access(1'b1, 1'b0, a, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0);
            end else if (r <= 8) begin
                run_access(1'b0, r >= 6, a, 2'($urandom), $urandom,
                           $urandom_range(0, 3) == 0, hf, a ^ 32'h4);
                if (hf) run_access(1'b1, 1'b0, a ^ 32'h4, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0);
            end else begin
                run_cancel(a, int'($urandom_range(1, 5)));
            end
            repeat ($urandom_range(0, 2)) begin
                step();
                check_idle("gap");
            end
        end

        foreach (shadow[addr]) check_eq("ram_final", 32'(ram_rd(addr)), 32'(shadow[addr]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
